fir_sample_sequencer: RTL and testbench

//  Input stage of the 4-band FIR datapath; sits directly upstream of the delay-element chain.

---
 rtl/fir_pkg.sv | 25 ++
 rtl/fir_sample_fifo.sv | 63 ++++++
 rtl/fir_sample_sequencer.sv | 120 ++++++++++++
 tb/tb_fir_sample_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and width helpers for the FIR input sequencer.
// No logic; state encoding and default geometry only.
// Imported by the sequencer top.
package fir_pkg;

    localparam int DATA_W     = 10;
    localparam int FIFO_DEPTH = 4;
    localparam int MAC_CYCLES = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DONE  = 2'd3
    } fir_state_e;

    // A single-cycle MAC still needs a 1-bit tap index port
    function automatic int tap_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TAP_W = tap_w(MAC_CYCLES);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

endpackage

// File: rtl/fir_sample_fifo.sv
// Register FIFO buffering input samples ahead of the delay chain.
// Latency: write visible at head one edge after push; pop is registered.
// Backpressure: push ignored when full, pop ignored when empty; flush empties it.
module fir_sample_fifo #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    cnt_q;
    logic              push_ok;
    logic              pop_ok;

    assign full_o    = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign push_ok   = push_i && !full_o && !flush_i;
    assign pop_ok    = pop_i && !empty_o && !flush_i;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = cnt_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Power-of-2 depth lets the pointers wrap by plain overflow
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/fir_sample_sequencer.sv
// Input stage of the FIR datapath: buffers samples, loads the delay chain, steps taps.
// Latency: sample pushed at edge E0 into an idle block shows on ld_d after edge E1.
// Backpressure: in_ready low when the FIFO is full or flush is asserted.
module fir_sample_sequencer #(
    parameter int DATA_W     = fir_pkg::DATA_W,
    parameter int FIFO_DEPTH = fir_pkg::FIFO_DEPTH,
    parameter int MAC_CYCLES = fir_pkg::MAC_CYCLES
) (
    input  logic                                    clk,
    input  logic                                    clr,
    input  logic                                    flush,
    input  logic [DATA_W-1:0]                       in_data,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    output logic                                    ld_d,
    output logic [DATA_W-1:0]                       delay_in,
    output logic                                    tap_en,
    output logic [fir_pkg::tap_w(MAC_CYCLES)-1:0]   tap_idx,
    output logic                                    frame_done,
    output logic [$clog2(FIFO_DEPTH):0]             fifo_count
);

    import fir_pkg::*;

    localparam int              TW       = tap_w(MAC_CYCLES);
    localparam logic [TW-1:0]   TAP_LAST = TW'(MAC_CYCLES - 1);

    fir_state_e         state_q, state_d;
    logic [TW-1:0]      tap_q, tap_d;
    logic               load_q, load_d;
    logic [DATA_W-1:0]  delay_q, delay_d;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [DATA_W-1:0]  fifo_head;

    assign in_ready = !fifo_full && !flush;
    assign push     = in_valid && in_ready;

    fir_sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .clr       (clr),
        .flush_i   (flush),
        .push_i    (push),
        .pop_i     (pop),
        .wr_data_i (in_data),
        .rd_data_o (fifo_head),
        .count_o   (fifo_count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        pop     = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
            tap_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_d = ST_LOAD;
                        pop     = 1'b1;
                    end
                end
                ST_LOAD: begin
                    state_d = ST_ACCUM;
                    tap_d   = '0;
                end
                ST_ACCUM: begin
                    if (tap_q == TAP_LAST) begin
                        state_d = ST_DONE;
                        tap_d   = '0;
                    end else begin
                        tap_d = tap_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!fifo_empty) begin
                        state_d = ST_LOAD;
                        pop     = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        load_d  = (state_d == ST_LOAD);
        // delay_in keeps the last loaded sample; ld_d qualifies it downstream
        delay_d = pop ? fifo_head : delay_q;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            tap_q   <= '0;
            load_q  <= 1'b0;
            delay_q <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            load_q  <= load_d;
            delay_q <= delay_d;
        end
    end

    assign ld_d       = load_q;
    assign delay_in   = delay_q;
    assign tap_en     = (state_q == ST_ACCUM);
    assign tap_idx    = tap_q;
    assign frame_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Bench for fir_sample_sequencer: default build plus a MAC_CYCLES=1 / FIFO_DEPTH=2 build.
// Accepted samples are queued and matched against delay_in whenever ld_d fires.
module tb_fir_sample_sequencer;

    localparam int M_A = 4;

    logic       clk;
    logic       clr;
    logic       flush;
    logic [9:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       ld_d;
    logic [9:0] delay_in;
    logic       tap_en;
    logic [1:0] tap_idx;
    logic       frame_done;
    logic [2:0] fifo_count;

    logic       flush_b;
    logic [9:0] in_data_b;
    logic       in_valid_b;
    logic       in_ready_b;
    logic       ld_d_b;
    logic [9:0] delay_in_b;
    logic       tap_en_b;
    logic [0:0] tap_idx_b;
    logic       frame_done_b;
    logic [1:0] fifo_count_b;

    fir_sample_sequencer u_dut (
        .clk(clk), .clr(clr), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ld_d(ld_d), .delay_in(delay_in), .tap_en(tap_en),
        .tap_idx(tap_idx), .frame_done(frame_done), .fifo_count(fifo_count)
    );

    fir_sample_sequencer #(.DATA_W(10), .FIFO_DEPTH(2), .MAC_CYCLES(1)) u_dut_b (
        .clk(clk), .clr(clr), .flush(flush_b), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .ld_d(ld_d_b), .delay_in(delay_in_b), .tap_en(tap_en_b),
        .tap_idx(tap_idx_b), .frame_done(frame_done_b), .fifo_count(fifo_count_b)
    );

    int total = 0;
    int bad   = 0;

    logic [9:0] q_a [$];
    logic [9:0] q_b [$];
    int  cyc = 0;
    int  ph = 0;
    int  prev_ld = -1;
    int  ld_cnt = 0;
    bit  abort_pend = 0;
    bit  rst_evt = 0;
    bit  gap_en = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_fd(input int max);
        int n = 0;
        while (!frame_done && n < max) begin
            step(1);
            n++;
        end
        chk("wait_frame_done", frame_done, 1);
    endtask

    // Default-build monitor: data scoreboard plus tap/frame sequencing after each load
    always @(negedge clk) begin
        int  ph_in;
        bit  abort_in;
        if (rst_evt || clr) begin
            q_a.delete();
            ph         = 0;
            prev_ld    = -1;
            abort_pend = 0;
            rst_evt    = 0;
        end else begin
            ph_in    = ph;
            abort_in = abort_pend;
            if (abort_pend) begin
                ph         = 0;
                abort_pend = 0;
            end else if (ph >= 1 && ph <= M_A) begin
                chk("tap_en", tap_en, 1);
                chk("tap_idx", tap_idx, ph - 1);
                ph++;
            end else if (ph == M_A + 1) begin
                chk("frame_done", frame_done, 1);
                ph = 0;
            end else begin
                chk("idle_frame_done", frame_done, 0);
                chk("idle_tap_en", tap_en, 0);
            end
            if (ld_d) begin
                chk("ld_slot", (!abort_in && ph_in == 0), 1);
                chk("sb_nonempty", q_a.size() != 0, 1);
                if (q_a.size() != 0) chk("delay_in", delay_in, q_a.pop_front());
                if (gap_en && prev_ld >= 0) chk("ld_gap", cyc - prev_ld, M_A + 2);
                prev_ld = cyc;
                ld_cnt++;
                ph = 1;
            end
            if (in_valid && in_ready) q_a.push_back(in_data);
            if (flush) begin
                chk("in_ready_flush", in_ready, 0);
                q_a.delete();
                abort_pend = 1;
            end
        end
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int        v;
        int        guard;
        bit        acc;
        bit        seen_full;
        int        prev_b;
        int        n_ld_b;
        logic [9:0] vb;

        clr = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        flush_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0;

        // Reset values while clr held, in_ready after release
        #12;
        chk("rst_ld_d", ld_d, 0);
        chk("rst_delay_in", delay_in, 0);
        chk("rst_tap_en", tap_en, 0);
        chk("rst_tap_idx", tap_idx, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_fifo_count", fifo_count, 0);
        clr = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        step(2);

        // Single sample latency and tap walk
        in_valid = 1'b1; in_data = 10'h2A5;
        step(1);
        in_valid = 1'b0;
        chk("single_cnt_e0", fifo_count, 1);
        chk("single_ld_e0", ld_d, 0);
        step(1);
        chk("single_ld_e1", ld_d, 1);
        chk("single_data", delay_in, 10'h2A5);
        chk("single_cnt_e1", fifo_count, 0);
        for (int k = 0; k < M_A; k++) begin
            step(1);
            chk("single_ld_off", ld_d, 0);
            chk("single_tap_en", tap_en, 1);
            chk("single_tap_idx", tap_idx, k);
        end
        step(1);
        chk("single_done", frame_done, 1);
        chk("single_done_tap", tap_en, 0);
        step(1);
        chk("single_done_off", frame_done, 0);
        chk("single_hold", delay_in, 10'h2A5);
        step(3);

        // Burst 1..6 with in_valid held high
        ld_cnt = 0; prev_ld = -1; gap_en = 1; seen_full = 0;
        v = 1; guard = 0;
        in_valid = 1'b1;
        while (v <= 6 && guard < 80) begin
            in_data = 10'(v);
            acc = in_ready;
            chk("burst_rdy", in_ready, fifo_count != 3'd4);
            if (fifo_count == 3'd4) seen_full = 1;
            step(1);
            if (acc) v++;
            guard++;
        end
        in_valid = 1'b0;
        chk("burst_all_sent", v, 7);
        step(50);
        chk("burst_full_seen", seen_full, 1);
        chk("burst_ld_cnt", ld_cnt, 6);
        chk("burst_sb_empty", q_a.size(), 0);
        gap_en = 0;

        // Push and pop on the same edge with count=2
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 10'h0A1 + 10'(k);
            step(1);
        end
        in_valid = 1'b0;
        wait_fd(20);
        chk("pp_cnt_before", fifo_count, 2);
        in_valid = 1'b1; in_data = 10'h0A4;
        step(1);
        in_valid = 1'b0;
        chk("pp_cnt_after", fifo_count, 2);
        chk("pp_ld", ld_d, 1);
        step(30);
        chk("pp_sb_empty", q_a.size(), 0);

        // Flush mid-ACCUM with three samples queued
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 10'h150 + 10'(k);
            step(1);
        end
        chk("fl_pre_idx", tap_idx, 1);
        chk("fl_pre_en", tap_en, 1);
        chk("fl_pre_cnt", fifo_count, 3);
        flush = 1'b1; in_data = 10'h3FF;
        #1;
        chk("fl_in_ready", in_ready, 0);
        step(1);
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_tap_en", tap_en, 0);
        chk("fl_cnt", fifo_count, 0);
        chk("fl_ld", ld_d, 0);
        chk("fl_tap_idx", tap_idx, 0);
        chk("fl_fd", frame_done, 0);
        for (int k = 0; k < 8; k++) begin
            step(1);
            chk("fl_no_fd", frame_done, 0);
            chk("fl_no_ld", ld_d, 0);
        end

        // MAC_CYCLES=1, FIFO_DEPTH=2 build: back-to-back loads
        vb = 10'h100; prev_b = -1; n_ld_b = 0;
        in_valid_b = 1'b1;
        for (int c = 0; c < 30; c++) begin
            in_data_b = vb;
            acc = in_ready_b;
            chk("b_cnt_max", fifo_count_b <= 2'd2, 1);
            if (ld_d_b) begin
                chk("b_sb_nonempty", q_b.size() != 0, 1);
                if (q_b.size() != 0) chk("b_delay_in", delay_in_b, q_b.pop_front());
                if (prev_b >= 0) chk("b_ld_gap", c - prev_b, 3);
                prev_b = c;
                n_ld_b++;
            end
            if (acc) begin
                q_b.push_back(vb);
                vb = vb + 10'd1;
            end
            step(1);
        end
        in_valid_b = 1'b0;
        chk("b_ld_count", n_ld_b, 10);

        // clr pulsed mid-sample between edges
        in_valid = 1'b1; in_data = 10'h1C3;
        step(1);
        in_valid = 1'b0;
        step(3);
        chk("mclr_pre_en", tap_en, 1);
        clr = 1'b1; rst_evt = 1'b1;
        #1;
        chk("mclr_ld", ld_d, 0);
        chk("mclr_delay", delay_in, 0);
        chk("mclr_tap_en", tap_en, 0);
        chk("mclr_tap_idx", tap_idx, 0);
        chk("mclr_fd", frame_done, 0);
        chk("mclr_cnt", fifo_count, 0);
        #1;
        clr = 1'b0;
        #1;
        chk("mclr_in_ready", in_ready, 1);
        step(4);
        chk("mclr_idle_en", tap_en, 0);
        chk("mclr_idle_ld", ld_d, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
